// File: rtl/andor_fabapb_arb.sv
// andor_fabapb_arb
// Two-requester round-robin arbiter and APB3 sequencer for the SmartFusion
// MSS fabric-to-MSS APB slave port (FABP* pins). Commands arrive on two
// valid/ready ports, are granted only while the CCC reports lock, and each
// one runs as a SETUP/ACCESS transfer with an optional ACCESS-phase timeout.
// Completion returns a one-cycle RSPn_VALID pulse for the granted requester
// with registered read data and an error flag held until the next completion.

module andor_fabapb_arb #(
  parameter int TIMEOUT = 256
) (
  input  logic        FAB_CLK,
  input  logic        M2FRESETn,
  input  logic        LOCK,

  input  logic        REQ0_VALID,
  output logic        REQ0_READY,
  input  logic        REQ0_WRITE,
  input  logic [31:0] REQ0_ADDR,
  input  logic [31:0] REQ0_WDATA,

  input  logic        REQ1_VALID,
  output logic        REQ1_READY,
  input  logic        REQ1_WRITE,
  input  logic [31:0] REQ1_ADDR,
  input  logic [31:0] REQ1_WDATA,

  output logic        RSP0_VALID,
  output logic        RSP1_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,

  output logic [31:0] FABPADDR,
  output logic [31:0] FABPWDATA,
  output logic        FABPWRITE,
  output logic        FABPSEL,
  output logic        FABPENABLE,
  input  logic [31:0] FABPRDATA,
  input  logic        FABPREADY,
  input  logic        FABPSLVERR,

  output logic        BUSY
);

  // Timeout limit as a 16-bit compare value; zero turns the timeout off.
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);
  localparam bit          TMO_EN    = (TIMEOUT != 0);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Round-robin pointer: names the requester favoured on a tie.
  logic        ptr;
  // Requester that owns the transfer currently on the bus.
  logic        owner;
  // ACCESS-phase wait-state counter (saturating, never wraps).
  logic [15:0] wait_cnt;

  logic        grant0;
  logic        grant1;
  logic        grant_any;
  logic        tmo_hit;
  logic        done_ready;
  logic        done_tmo;
  logic        done;

  // Winner selection: only in IDLE, only with lock, never while in reset.
  // A tie goes to the pointer's requester, a lone request always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state == IDLE) && LOCK && M2FRESETn) begin
      if (REQ0_VALID && REQ1_VALID) begin
        grant0 = ~ptr;
        grant1 = ptr;
      end else begin
        grant0 = REQ0_VALID;
        grant1 = REQ1_VALID;
      end
    end
  end

  assign REQ0_READY = grant0;
  assign REQ1_READY = grant1;
  assign grant_any  = grant0 | grant1;

  // A transfer ends on PREADY, or on the timeout edge if PREADY is still low.
  assign tmo_hit    = TMO_EN && (wait_cnt == TMO_LIMIT);
  assign done_ready = (state == ACCESS) && FABPREADY;
  assign done_tmo   = (state == ACCESS) && !FABPREADY && tmo_hit;
  assign done       = done_ready | done_tmo;

  // FSM state register.
  always_ff @(posedge FAB_CLK or negedge M2FRESETn) begin
    if (!M2FRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and APB phase controls derived from the state.
  always_comb begin
    state_nxt  = state;
    FABPSEL    = 1'b0;
    FABPENABLE = 1'b0;
    BUSY       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        FABPSEL   = 1'b1;
        BUSY      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        FABPSEL    = 1'b1;
        FABPENABLE = 1'b1;
        BUSY       = 1'b1;
        if (done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Round-robin pointer and transfer owner: after a grant the other
  // requester becomes favoured.
  always_ff @(posedge FAB_CLK or negedge M2FRESETn) begin
    if (!M2FRESETn) begin
      ptr   <= 1'b0;
      owner <= 1'b0;
    end else if (grant_any) begin
      ptr   <= grant0;
      owner <= grant1;
    end
  end

  // Command capture into the APB address/data/direction registers; they
  // hold their values between transfers.
  always_ff @(posedge FAB_CLK or negedge M2FRESETn) begin
    if (!M2FRESETn) begin
      FABPADDR  <= 32'd0;
      FABPWDATA <= 32'd0;
      FABPWRITE <= 1'b0;
    end else if (grant_any) begin
      FABPADDR  <= grant1 ? REQ1_ADDR  : REQ0_ADDR;
      FABPWDATA <= grant1 ? REQ1_WDATA : REQ0_WDATA;
      FABPWRITE <= grant1 ? REQ1_WRITE : REQ0_WRITE;
    end
  end

  // Wait counter: cleared in SETUP so it reads zero on the first ACCESS
  // cycle, then counts ACCESS cycles without PREADY, saturating at all-ones.
  always_ff @(posedge FAB_CLK or negedge M2FRESETn) begin
    if (!M2FRESETn) begin
      wait_cnt <= 16'd0;
    end else if (state == SETUP) begin
      wait_cnt <= 16'd0;
    end else if ((state == ACCESS) && !FABPREADY && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Completion pulse routed to the owning requester.
  always_ff @(posedge FAB_CLK or negedge M2FRESETn) begin
    if (!M2FRESETn) begin
      RSP0_VALID <= 1'b0;
      RSP1_VALID <= 1'b0;
    end else begin
      RSP0_VALID <= done & ~owner;
      RSP1_VALID <= done & owner;
    end
  end

  // Response payload: read data only for a read that saw PREADY; a write
  // or a timeout returns zero. Held until the next completion.
  always_ff @(posedge FAB_CLK or negedge M2FRESETn) begin
    if (!M2FRESETn) begin
      RSP_RDATA <= 32'd0;
      RSP_ERR   <= 1'b0;
    end else if (done_ready) begin
      RSP_RDATA <= FABPWRITE ? 32'd0 : FABPRDATA;
      RSP_ERR   <= FABPSLVERR;
    end else if (done_tmo) begin
      RSP_RDATA <= 32'd0;
      RSP_ERR   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_andor_fabapb_arb.sv
// Testbench for andor_fabapb_arb: directed scenarios followed by randomized
// traffic, checked against a transaction-level model kept in the bench.
// Expected responses go into a scoreboard queue; a separate monitor pops and
// compares them whenever the DUT pulses RSP0_VALID or RSP1_VALID.

module tb_andor_fabapb_arb;

  localparam int TO = 4;

  logic        FAB_CLK = 1'b0;
  logic        M2FRESETn;
  logic        LOCK;
  logic        REQ0_VALID, REQ0_READY, REQ0_WRITE;
  logic [31:0] REQ0_ADDR, REQ0_WDATA;
  logic        REQ1_VALID, REQ1_READY, REQ1_WRITE;
  logic [31:0] REQ1_ADDR, REQ1_WDATA;
  logic        RSP0_VALID, RSP1_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [31:0] FABPADDR, FABPWDATA;
  logic        FABPWRITE, FABPSEL, FABPENABLE;
  logic [31:0] FABPRDATA;
  logic        FABPREADY, FABPSLVERR;
  logic        BUSY;

  andor_fabapb_arb #(.TIMEOUT(TO)) dut (
    .FAB_CLK    (FAB_CLK),
    .M2FRESETn  (M2FRESETn),
    .LOCK       (LOCK),
    .REQ0_VALID (REQ0_VALID),
    .REQ0_READY (REQ0_READY),
    .REQ0_WRITE (REQ0_WRITE),
    .REQ0_ADDR  (REQ0_ADDR),
    .REQ0_WDATA (REQ0_WDATA),
    .REQ1_VALID (REQ1_VALID),
    .REQ1_READY (REQ1_READY),
    .REQ1_WRITE (REQ1_WRITE),
    .REQ1_ADDR  (REQ1_ADDR),
    .REQ1_WDATA (REQ1_WDATA),
    .RSP0_VALID (RSP0_VALID),
    .RSP1_VALID (RSP1_VALID),
    .RSP_RDATA  (RSP_RDATA),
    .RSP_ERR    (RSP_ERR),
    .FABPADDR   (FABPADDR),
    .FABPWDATA  (FABPWDATA),
    .FABPWRITE  (FABPWRITE),
    .FABPSEL    (FABPSEL),
    .FABPENABLE (FABPENABLE),
    .FABPRDATA  (FABPRDATA),
    .FABPREADY  (FABPREADY),
    .FABPSLVERR (FABPSLVERR),
    .BUSY       (BUSY)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int cyc = 0;
  always @(posedge FAB_CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;
  rsp_t exp_q[$];

  // Transaction-level model state.
  int          ptr = 0;
  bit          busy = 0;
  int          g_cyc = 0;
  int          done_cyc = 0;
  int          w_cur = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, c_rdata = 0;
  logic        c_write = 0, c_err = 0;

  // Slave behaviour for the next granted transfer (when plan_set).
  bit          plan_set = 0;
  int          plan_w = 0;
  logic [31:0] plan_rdata = 0;
  logic        plan_err = 0;

  bit          rnd_mode = 0;
  bit          keep = 0;
  int          dut_grants[$];
  int          dual_ready = 0;
  logic [31:0] last_rdata = 0;
  logic        last_err = 0;

  task automatic chk1(input string name, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, exp_v);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp_v);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s cycle=%0d actual=expired required=completed", name, cyc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_ready0"}, REQ0_READY, 1'b0);
    chk1({tag, "_ready1"}, REQ1_READY, 1'b0);
    chk1({tag, "_rsp0"}, RSP0_VALID, 1'b0);
    chk1({tag, "_rsp1"}, RSP1_VALID, 1'b0);
    chk32({tag, "_rdata"}, RSP_RDATA, 32'd0);
    chk1({tag, "_err"}, RSP_ERR, 1'b0);
    chk32({tag, "_paddr"}, FABPADDR, 32'd0);
    chk32({tag, "_pwdata"}, FABPWDATA, 32'd0);
    chk1({tag, "_pwrite"}, FABPWRITE, 1'b0);
    chk1({tag, "_psel"}, FABPSEL, 1'b0);
    chk1({tag, "_penable"}, FABPENABLE, 1'b0);
    chk1({tag, "_busy"}, BUSY, 1'b0);
  endtask

  task automatic set_cmd(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (r == 0) begin
      REQ0_VALID = 1'b1; REQ0_WRITE = wr; REQ0_ADDR = a; REQ0_WDATA = d;
    end else begin
      REQ1_VALID = 1'b1; REQ1_WRITE = wr; REQ1_ADDR = a; REQ1_WDATA = d;
    end
  endtask

  task automatic new_cmd(input int r);
    set_cmd(r, 1'($urandom), $urandom, $urandom);
  endtask

  task automatic plan(input int w, input logic [31:0] rd, input logic er);
    plan_set = 1; plan_w = w; plan_rdata = rd; plan_err = er;
  endtask

  // One clock cycle: at the falling edge compare the DUT against the model,
  // accept a predicted grant into the model, drive the APB slave; after the
  // rising edge update requester stimulus.
  task automatic step();
    bit   g0, g1, idle, setup, access, tmo;
    int   id;
    rsp_t e;
    @(negedge FAB_CLK);
    if (busy && cyc >= done_cyc) busy = 0;
    idle   = !busy;
    setup  = busy && (cyc == g_cyc + 1);
    access = busy && (cyc > g_cyc + 1);
    g0 = 0;
    g1 = 0;
    if (idle && LOCK && M2FRESETn) begin
      if (REQ0_VALID && REQ1_VALID) begin
        if (ptr == 0) g0 = 1; else g1 = 1;
      end else if (REQ0_VALID) g0 = 1;
      else if (REQ1_VALID) g1 = 1;
    end
    if (REQ0_READY) dut_grants.push_back(0);
    if (REQ1_READY) dut_grants.push_back(1);
    if (REQ0_READY && REQ1_READY) dual_ready++;
    chk1("ready0", REQ0_READY, g0);
    chk1("ready1", REQ1_READY, g1);
    chk1("busy", BUSY, !idle);
    chk1("psel", FABPSEL, setup || access);
    chk1("penable", FABPENABLE, access);
    if (setup || access) begin
      chk32("paddr", FABPADDR, c_addr);
      chk32("pwdata", FABPWDATA, c_wdata);
      chk1("pwrite", FABPWRITE, c_write);
    end
    FABPREADY  = 1'b0;
    FABPRDATA  = $urandom;
    FABPSLVERR = 1'($urandom);
    if (access && (cyc - (g_cyc + 2)) == w_cur) begin
      FABPREADY  = 1'b1;
      FABPRDATA  = c_rdata;
      FABPSLVERR = c_err;
    end
    if (g0 || g1) begin
      id      = g1 ? 1 : 0;
      busy    = 1;
      g_cyc   = cyc;
      c_write = g1 ? REQ1_WRITE : REQ0_WRITE;
      c_addr  = g1 ? REQ1_ADDR  : REQ0_ADDR;
      c_wdata = g1 ? REQ1_WDATA : REQ0_WDATA;
      if (plan_set) begin
        w_cur = plan_w; c_rdata = plan_rdata; c_err = plan_err; plan_set = 0;
      end else begin
        w_cur   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 3));
        c_rdata = $urandom;
        c_err   = ($urandom_range(0, 5) == 0);
      end
      tmo      = (TO != 0) && (w_cur > TO);
      done_cyc = cyc + 3 + (tmo ? TO : w_cur);
      e.id     = id;
      e.cyc    = done_cyc;
      e.err    = tmo ? 1'b1 : c_err;
      e.rdata  = (tmo || c_write) ? 32'd0 : c_rdata;
      exp_q.push_back(e);
      ptr = 1 - id;
    end
    @(posedge FAB_CLK);
    #1;
    if (g0) begin
      if (keep || (rnd_mode && $urandom_range(0, 1) == 1)) new_cmd(0); else REQ0_VALID = 1'b0;
    end else if (rnd_mode) begin
      if (!REQ0_VALID && $urandom_range(0, 2) == 0) new_cmd(0);
      else if (REQ0_VALID && $urandom_range(0, 15) == 0) REQ0_VALID = 1'b0;
    end
    if (g1) begin
      if (keep || (rnd_mode && $urandom_range(0, 1) == 1)) new_cmd(1); else REQ1_VALID = 1'b0;
    end else if (rnd_mode) begin
      if (!REQ1_VALID && $urandom_range(0, 2) == 0) new_cmd(1);
      else if (REQ1_VALID && $urandom_range(0, 15) == 0) REQ1_VALID = 1'b0;
    end
    if (rnd_mode) LOCK = ($urandom_range(0, 7) != 0);
  endtask

  task automatic drain(input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      if (!busy && !REQ0_VALID && !REQ1_VALID) return;
      step();
    end
    fail_now(tag);
  endtask

  // Response monitor: compares every completion pulse with the scoreboard.
  initial begin
    rsp_t e;
    forever begin
      @(negedge FAB_CLK);
      if (!M2FRESETn) begin
        last_rdata = 32'd0;
        last_err   = 1'b0;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        fail_now($sformatf("rsp_missing_req%0d_due%0d", e.id, e.cyc));
      end
      if (RSP0_VALID || RSP1_VALID) begin
        chk1("rsp_onehot", RSP0_VALID && RSP1_VALID, 1'b0);
        if (exp_q.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk32("rsp_id", RSP1_VALID ? 32'd1 : 32'd0, 32'(e.id));
          chk32("rsp_cycle", 32'(cyc), 32'(e.cyc));
          chk32("rsp_rdata", RSP_RDATA, e.rdata);
          chk1("rsp_err", RSP_ERR, e.err);
          last_rdata = e.rdata;
          last_err   = e.err;
        end
      end else begin
        chk32("rsp_rdata_hold", RSP_RDATA, last_rdata);
        chk1("rsp_err_hold", RSP_ERR, last_err);
      end
    end
  end

  initial begin
    int exp_order[4] = '{0, 1, 0, 1};

    // Reset with a live request and lock: nothing may be granted.
    M2FRESETn = 1'b0; LOCK = 1'b1;
    REQ0_VALID = 1'b1; REQ0_WRITE = 1'b1; REQ0_ADDR = 32'h4000_0010; REQ0_WDATA = 32'h1;
    REQ1_VALID = 1'b0; REQ1_WRITE = 1'b0; REQ1_ADDR = 32'd0; REQ1_WDATA = 32'd0;
    FABPREADY = 1'b0; FABPRDATA = 32'd0; FABPSLVERR = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    chk_all_zero("reset");
    @(posedge FAB_CLK);
    #1;
    REQ0_VALID = 1'b0;
    M2FRESETn  = 1'b1;

    // Write, zero wait states.
    set_cmd(0, 1'b1, 32'h4000_6000, 32'hA5A5_0001);
    plan(0, 32'h1357_9BDF, 1'b0);
    drain(20, "write0_drain");

    // Read with 3 wait states.
    set_cmd(1, 1'b0, 32'h4000_2000, 32'h0);
    plan(3, 32'hDEAD_BEEF, 1'b0);
    drain(20, "read3_drain");

    // Contention: both requesters valid for four transfers.
    dut_grants.delete();
    dual_ready = 0;
    keep = 1;
    new_cmd(0);
    new_cmd(1);
    for (int i = 0; i < 80 && dut_grants.size() < 4; i++) step();
    keep = 0;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    drain(20, "contention_drain");
    if (dut_grants.size() < 4) fail_now("contention_grants");
    else for (int i = 0; i < 4; i++) chk32("grant_order", 32'(dut_grants[i]), 32'(exp_order[i]));
    chk32("dual_ready", 32'(dual_ready), 32'd0);

    // Timeout with PREADY held low, then SLVERR with normal latency.
    set_cmd(0, 1'b0, 32'h4000_3000, 32'h0);
    plan(10, 32'hFFFF_FFFF, 1'b0);
    drain(30, "timeout_drain");
    set_cmd(1, 1'b1, 32'h4000_3004, 32'h0BAD_F00D);
    plan(0, 32'h0, 1'b1);
    drain(20, "slverr_drain");

    // LOCK gating: request waits while LOCK is low, granted once it rises.
    LOCK = 1'b0;
    set_cmd(0, 1'b1, 32'h4000_4000, 32'h0000_CAFE);
    repeat (10) step();
    LOCK = 1'b1;
    drain(20, "lock_rise_drain");
    // LOCK dropping mid-ACCESS does not abort the transfer.
    set_cmd(1, 1'b0, 32'h4000_4004, 32'h0);
    plan(3, 32'h600D_D00D, 1'b0);
    repeat (3) step();
    LOCK = 1'b0;
    drain(20, "lock_drop_drain");
    LOCK = 1'b1;

    // Reset during ACCESS: outputs clear at once, no response pulse.
    set_cmd(0, 1'b0, 32'h4000_5000, 32'h0);
    plan(10, 32'h1111_2222, 1'b0);
    repeat (3) step();
    M2FRESETn = 1'b0;
    #1;
    chk_all_zero("reset_mid");
    exp_q.delete();
    busy = 0;
    ptr = 0;
    REQ0_VALID = 1'b0;
    set_cmd(1, 1'b1, 32'h4000_5004, 32'h7777_8888);
    repeat (2) step();
    M2FRESETn = 1'b1;
    drain(20, "post_reset_drain");

    // Randomized traffic with random lock, withdrawals and wait states.
    rnd_mode = 1;
    repeat (3000) step();
    rnd_mode = 0;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    LOCK = 1'b1;
    drain(40, "random_drain");
    repeat (2) step();
    chk32("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
